pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 145 ++++++++++++++
 tb/tb_pc_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/FLUSH/HALT control with relative branches and post-branch flush.
// Optional PC_WRAP_TRAP_EN: PC carry-out in RUN raises a sticky pc_fault and halts.
module pc_sequencer #(
    parameter int unsigned                 INST_ADDR_WIDTH = 16,
    parameter logic [INST_ADDR_WIDTH-1:0]  RESET_VECTOR    = '0,
    parameter int unsigned                 FLUSH_CYCLES    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       stall,
    input  logic                       branch_req,
    input  logic                       jump,
    input  logic [INST_ADDR_WIDTH-1:0] inst_1,
    input  logic [INST_ADDR_WIDTH-1:0] inst_2,
    input  logic                       halt_req,
    output logic [INST_ADDR_WIDTH-1:0] pc,
    output logic                       inst_valid,
    output logic                       flush,
    output logic [1:0]                 state
`ifdef PC_WRAP_TRAP_EN
    ,
    output logic                       pc_fault
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10,
        ST_HALT  = 2'b11
    } state_e;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_e                     state_q, state_d;
    logic [INST_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic [INST_ADDR_WIDTH-1:0] offset, target, pc_inc;

    assign offset = jump ? inst_2 : inst_1;

`ifdef PC_WRAP_TRAP_EN
    logic target_co, inc_co;
    logic fault_q, fault_d;

    assign {target_co, target} = {1'b0, pc_q} + {1'b0, offset};
    assign {inc_co, pc_inc}    = {1'b0, pc_q} + (INST_ADDR_WIDTH+1)'(1);
    assign pc_fault            = fault_q;
`else
    assign target = pc_q + offset;
    assign pc_inc = pc_q + INST_ADDR_WIDTH'(1);
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
`ifdef PC_WRAP_TRAP_EN
        fault_d = fault_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                pc_d = RESET_VECTOR;
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (stall) begin
                    state_d = ST_RUN;
                end else if (branch_req) begin
`ifdef PC_WRAP_TRAP_EN
                    if (target_co) begin
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = target;
                        cnt_d   = FLUSH_LOAD;
                        state_d = ST_FLUSH;
                    end
`else
                    pc_d    = target;
                    cnt_d   = FLUSH_LOAD;
                    state_d = ST_FLUSH;
`endif
                end else begin
`ifdef PC_WRAP_TRAP_EN
                    if (inc_co) begin
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_inc;
                    end
`else
                    pc_d = pc_inc;
`endif
                end
            end
            ST_FLUSH: begin
                // Counter holds remaining cycles minus one, so FLUSH spans exactly FLUSH_CYCLES.
                if (halt_req) begin
                    state_d = ST_HALT;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HALT: begin
`ifdef PC_WRAP_TRAP_EN
                if (start && !fault_q) state_d = ST_RUN;
`else
                if (start) state_d = ST_RUN;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_VECTOR;
            cnt_q   <= '0;
`ifdef PC_WRAP_TRAP_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
`ifdef PC_WRAP_TRAP_EN
            fault_q <= fault_d;
`endif
        end
    end

    assign pc         = pc_q;
    assign state      = state_q;
    assign flush      = (state_q == ST_FLUSH);
    assign inst_valid = (state_q == ST_RUN) && !stall;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed vector table, hand-written corner sequences, random run vs. model.
module tb_pc_sequencer;

    localparam int unsigned AW = 16;
`ifdef PC_WRAP_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, start, stall, branch_req, jump, halt_req;
    logic [AW-1:0] inst_1, inst_2, pc;
    logic          inst_valid, flush;
    logic [1:0]    state;
    logic          fault_obs;

    int tests  = 0;
    int failed = 0;

    // Model: state 0..3, pc as a plain integer, flush_left counts remaining flush cycles.
    int          m_st;
    int unsigned m_pc;
    int          m_left;
    bit          m_fault;

    always #5 clk = ~clk;

`ifdef PC_WRAP_TRAP_EN
    logic pc_fault;
    assign fault_obs = pc_fault;
`else
    assign fault_obs = 1'b0;
`endif

    pc_sequencer #(
        .INST_ADDR_WIDTH(AW),
        .RESET_VECTOR   (16'h0000),
        .FLUSH_CYCLES   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stall     (stall),
        .branch_req(branch_req),
        .jump      (jump),
        .inst_1    (inst_1),
        .inst_2    (inst_2),
        .halt_req  (halt_req),
        .pc        (pc),
        .inst_valid(inst_valid),
        .flush     (flush),
        .state     (state)
`ifdef PC_WRAP_TRAP_EN
        ,
        .pc_fault  (pc_fault)
`endif
    );

    typedef struct {
        logic          s, stl, b, j;
        logic [AW-1:0] i1, i2;
        logic          h;
        logic [AW-1:0] epc;
        logic [1:0]    est;
        logic          ev, ef;
    } vec_t;

    vec_t tbl[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic s, input logic stl, input logic b, input logic j,
                         input logic [AW-1:0] i1, input logic [AW-1:0] i2, input logic h);
        start = s; stall = stl; branch_req = b; jump = j;
        inst_1 = i1; inst_2 = i2; halt_req = h;
    endtask

    task automatic model_reset();
        m_st = 0; m_pc = 0; m_left = 0; m_fault = 1'b0;
    endtask

    task automatic model_step();
        int unsigned nxt;
        case (m_st)
            0: if (start) m_st = 1;
            1: begin
                if (halt_req) m_st = 3;
                else if (!stall) begin
                    nxt = branch_req ? m_pc + (jump ? inst_2 : inst_1) : m_pc + 1;
                    if (TRAP && nxt > 32'hFFFF) begin
                        m_fault = 1'b1;
                        m_st    = 3;
                    end else begin
                        m_pc = nxt % 65536;
                        if (branch_req) begin
                            m_left = 2;
                            m_st   = 2;
                        end
                    end
                end
            end
            2: begin
                if (halt_req) begin
                    m_st = 3; m_left = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) m_st = 1;
                end
            end
            default: if (start && !m_fault) m_st = 1;
        endcase
    endtask

    task automatic check_model();
        check("pc",         32'(pc),         m_pc);
        check("state",      32'(state),      32'(m_st));
        check("inst_valid", 32'(inst_valid), 32'(m_st == 1 && !stall));
        check("flush",      32'(flush),      32'(m_st == 2));
        check("pc_fault",   32'(fault_obs),  32'(m_fault));
    endtask

    // One clock: inputs already at posedge+1; sample at +3, step through the edge, return at posedge+1.
    task automatic cycle(input logic s, input logic stl, input logic b, input logic j,
                         input logic [AW-1:0] i1, input logic [AW-1:0] i2, input logic h);
        apply(s, stl, b, j, i1, i2, h);
        #2;
        check_model();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        apply(0, 0, 0, 0, '0, '0, 0);
        rst_n = 1'b0;
        #2;
        check("async_rst_pc",    32'(pc),    32'h0);
        check("async_rst_state", 32'(state), 32'h0);
        #3;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic vec_t mk(input logic s, input logic stl, input logic b, input logic j,
                                input logic [AW-1:0] i1, input logic [AW-1:0] i2, input logic h,
                                input logic [AW-1:0] epc, input logic [1:0] est,
                                input logic ev, input logic ef);
        vec_t v;
        v.s = s; v.stl = stl; v.b = b; v.j = j; v.i1 = i1; v.i2 = i2; v.h = h;
        v.epc = epc; v.est = est; v.ev = ev; v.ef = ef;
        return v;
    endfunction

    initial begin
        tbl[0]  = mk(1,0,0,0,16'h0000,16'h0000,0, 16'h0000,2'b00,0,0);
        tbl[1]  = mk(0,0,0,0,16'h0000,16'h0000,0, 16'h0000,2'b01,1,0);
        tbl[2]  = mk(0,0,0,0,16'h0000,16'h0000,0, 16'h0001,2'b01,1,0);
        tbl[3]  = mk(0,0,0,0,16'h0000,16'h0000,0, 16'h0002,2'b01,1,0);
        tbl[4]  = mk(0,1,0,0,16'h0000,16'h0000,0, 16'h0003,2'b01,0,0);
        tbl[5]  = mk(0,0,0,0,16'h0000,16'h0000,1, 16'h0003,2'b01,1,0);
        tbl[6]  = mk(0,0,0,0,16'h0000,16'h0000,0, 16'h0003,2'b11,0,0);
        tbl[7]  = mk(1,0,0,0,16'h0000,16'h0000,1, 16'h0003,2'b11,0,0);
        tbl[8]  = mk(0,0,1,0,16'h0020,16'h0000,0, 16'h0003,2'b01,1,0);
        tbl[9]  = mk(0,1,1,0,16'h0020,16'h0000,0, 16'h0023,2'b10,0,1);
        tbl[10] = mk(1,0,0,0,16'h0000,16'h0000,0, 16'h0023,2'b10,0,1);
        tbl[11] = mk(0,0,0,0,16'h0000,16'h0000,0, 16'h0023,2'b01,1,0);
        tbl[12] = mk(0,1,1,1,16'h0000,16'h0100,0, 16'h0024,2'b01,0,0);
        tbl[13] = mk(0,0,1,1,16'h0000,16'h0100,0, 16'h0024,2'b01,1,0);
        tbl[14] = mk(0,0,0,0,16'h0000,16'h0000,1, 16'h0124,2'b10,0,1);
        tbl[15] = mk(0,0,0,0,16'h0000,16'h0000,0, 16'h0124,2'b11,0,0);
        tbl[16] = mk(1,0,0,0,16'h0000,16'h0000,0, 16'h0124,2'b11,0,0);
        tbl[17] = mk(0,0,0,0,16'h0000,16'h0000,0, 16'h0124,2'b01,1,0);
        tbl[18] = mk(0,0,0,0,16'h0000,16'h0000,0, 16'h0125,2'b01,1,0);

        rst_n = 1'b0;
        apply(0, 0, 0, 0, '0, '0, 0);
        model_reset();
        #2;
        check("reset_pc",    32'(pc),         32'h0);
        check("reset_state", 32'(state),      32'h0);
        check("reset_valid", 32'(inst_valid), 32'h0);
        check("reset_flush", 32'(flush),      32'h0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        model_step();
        #1;

        // Directed table: expected outputs are those seen with the row's inputs, before its edge.
        for (int i = 0; i < 19; i++) begin
            apply(tbl[i].s, tbl[i].stl, tbl[i].b, tbl[i].j, tbl[i].i1, tbl[i].i2, tbl[i].h);
            #2;
            check($sformatf("tbl%0d_pc", i),    32'(pc),         32'(tbl[i].epc));
            check($sformatf("tbl%0d_state", i), 32'(state),      32'(tbl[i].est));
            check($sformatf("tbl%0d_valid", i), 32'(inst_valid), 32'(tbl[i].ev));
            check($sformatf("tbl%0d_flush", i), 32'(flush),      32'(tbl[i].ef));
            @(posedge clk);
            model_step();
            #1;
        end

        // Branch at 0x0010 with offset 0x0020, two flush cycles, then resume.
        do_reset();
        cycle(1,0,0,0,'0,'0,0);
        cycle(0,0,1,0,16'h0010,'0,0);
        cycle(0,0,0,0,'0,'0,0);
        cycle(0,0,0,0,'0,'0,0);
        check("at_0010", 32'(pc), 32'h0010);
        cycle(0,0,1,0,16'h0020,'0,0);
        check("br_pc", 32'(pc), 32'h0030);
        check("br_flush1", 32'(flush), 32'h1);
        cycle(0,0,0,0,'0,'0,0);
        check("br_flush2", 32'(flush), 32'h1);
        cycle(0,0,0,0,'0,'0,0);
        check("br_run3", 32'(state), 32'h1);
        cycle(0,0,0,0,'0,'0,0);
        check("br_after", 32'(pc), 32'h0031);

        // Jump from 0x0040 with offset 0xFFF0: stall first, then taken.
        cycle(0,0,1,0,16'h000F,'0,0);
        cycle(0,0,0,0,'0,'0,0);
        cycle(0,0,0,0,'0,'0,0);
        check("at_0040", 32'(pc), 32'h0040);
        cycle(0,1,1,1,'0,16'hFFF0,0);
        check("stall_hold", 32'(pc), 32'h0040);
        cycle(0,0,1,1,'0,16'hFFF0,0);
        if (TRAP) begin
            check("jmp_trap_pc",    32'(pc),    32'h0040);
            check("jmp_trap_state", 32'(state), 32'h3);
        end else begin
            check("jmp_pc",    32'(pc),    32'h0030);
            check("jmp_state", 32'(state), 32'h2);
            cycle(0,0,0,0,'0,'0,1);
            check("flush_halt_state", 32'(state), 32'h3);
            check("flush_halt_flush", 32'(flush), 32'h0);
            cycle(1,0,0,0,'0,'0,0);
            check("resume_state", 32'(state), 32'h1);
            check("resume_pc",    32'(pc),    32'h0030);
        end

        // Asynchronous reset mid-FLUSH, then wait in IDLE without start.
        do_reset();
        cycle(1,0,0,0,'0,'0,0);
        cycle(0,0,1,0,16'h0100,'0,0);
        check("pre_rst_flush", 32'(flush), 32'h1);
        do_reset();
        cycle(0,0,0,0,'0,'0,0);
        check("idle_wait_state", 32'(state), 32'h0);

        // Increment past 0xFFFF.
        cycle(1,0,0,0,'0,'0,0);
        cycle(0,0,1,0,16'hFFFF,'0,0);
        cycle(0,0,0,0,'0,'0,0);
        cycle(0,0,0,0,'0,'0,0);
        check("at_ffff", 32'(pc), 32'hFFFF);
        cycle(0,0,0,0,'0,'0,0);
        if (TRAP) begin
            check("wrap_fault", 32'(fault_obs), 32'h1);
            check("wrap_state", 32'(state),     32'h3);
            check("wrap_pc",    32'(pc),        32'hFFFF);
            cycle(1,0,0,0,'0,'0,0);
            check("fault_start_ignored", 32'(state), 32'h3);
        end else begin
            check("wrap_pc",    32'(pc),    32'h0000);
            check("wrap_state", 32'(state), 32'h1);
        end

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 3) == 0,
                      $urandom_range(0, 4) == 0,
                      $urandom_range(0, 4) == 0,
                      1'($urandom),
                      ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 64)),
                      ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 64)),
                      $urandom_range(0, 19) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
